// File: rtl/key_counter.sv
// rtl/key_counter.sv - debounced up/down push-button counter with wrap or saturate
//
// key_counter_debounce: one key channel (synchronizer + debounce FSM + press strobe)
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   key_n    in   raw active-low key, asynchronous, bouncing
//   pulse    out  one-cycle strobe per qualified press
//
// key_counter: top level
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   key_up_n in   raw active-low increment key
//   key_dn_n in   raw active-low decrement key
//   clr      in   synchronous count clear
//   count    out  4-bit registered count
//   up_pulse out  qualified up press strobe
//   dn_pulse out  qualified down press strobe
//   wrap_evt out  strobe in the cycle a wrapped value first appears on count

module key_counter_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pulse_nx;
    logic          key_meta, key_s;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    // The strobe is registered together with the state change,
                    // so it is high in exactly the cycle after qualification.
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    pulse_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    // Release bounce: return to PRESSED silently.
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
            state    <= state_nx;
            cnt      <= cnt_nx;
            pulse    <= pulse_nx;
        end
    end
endmodule

module key_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit WRAP            = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       clr,
    output logic [3:0] count,
    output logic       up_pulse,
    output logic       dn_pulse,
    output logic       wrap_evt
);
    key_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_up_n),
        .pulse (up_pulse)
    );

    key_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_dn_n),
        .pulse (dn_pulse)
    );

    // Counting consumes the registered strobes, so the new value shows up
    // one cycle after the pulse. Simultaneous up and down cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 4'd0;
            wrap_evt <= 1'b0;
        end else begin
            wrap_evt <= 1'b0;
            if (clr) begin
                count <= 4'd0;
            end else if (up_pulse && !dn_pulse) begin
                if (count == 4'hF) begin
                    if (WRAP) begin
                        count    <= 4'd0;
                        wrap_evt <= 1'b1;
                    end
                end else begin
                    count <= count + 4'd1;
                end
            end else if (dn_pulse && !up_pulse) begin
                if (count == 4'h0) begin
                    if (WRAP) begin
                        count    <= 4'hF;
                        wrap_evt <= 1'b1;
                    end
                end else begin
                    count <= count - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_counter.sv
// tb/tb_key_counter.sv - scoreboard bench for key_counter (wrap and saturate builds)
module tb_key_counter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, key_up_n, key_dn_n, clr;
    logic [3:0] count_w1, count_w0;
    logic       up_w1, dn_w1, wrap_w1;
    logic       up_w0, dn_w0, wrap_w0;

    key_counter #(.DEBOUNCE_CYCLES(N), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n), .clr(clr),
        .count(count_w1), .up_pulse(up_w1), .dn_pulse(dn_w1), .wrap_evt(wrap_w1)
    );

    key_counter #(.DEBOUNCE_CYCLES(N), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n), .clr(clr),
        .count(count_w0), .up_pulse(up_w0), .dn_pulse(dn_w0), .wrap_evt(wrap_w0)
    );

    typedef struct packed {
        logic       up;
        logic       dn;
        logic [3:0] c1;
        logic       w1;
        logic [3:0] c0;
        logic       w0;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: raw key samples are delayed two edges, then a key's
    // debounced level flips once N+1 consecutive samples disagree with it.
    bit s1[2], s2[2], pressed[2], m_pulse[2];
    int run[2];
    int m_c1, m_c0;
    bit m_w1, m_w0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    task automatic model_edge(input bit rn, input bit ku, input bit kd, input bit cl);
        bit raw[2];
        bit np[2];
        bit agree;
        int d;
        raw[0] = ku;
        raw[1] = kd;
        if (!rn) begin
            for (int k = 0; k < 2; k++) begin
                s1[k] = 1; s2[k] = 1; pressed[k] = 0; run[k] = 0; m_pulse[k] = 0;
            end
            m_c1 = 0; m_c0 = 0; m_w1 = 0; m_w0 = 0;
        end else begin
            m_w1 = 0;
            m_w0 = 0;
            if (cl) begin
                m_c1 = 0;
                m_c0 = 0;
            end else if (m_pulse[0] != m_pulse[1]) begin
                d = m_pulse[0] ? 1 : -1;
                if (m_c1 + d > 15 || m_c1 + d < 0) begin
                    m_c1 = (m_c1 + d + 16) % 16;
                    m_w1 = 1;
                end else begin
                    m_c1 = m_c1 + d;
                end
                m_c0 = m_c0 + d;
                if (m_c0 > 15) m_c0 = 15;
                if (m_c0 < 0) m_c0 = 0;
            end
            for (int k = 0; k < 2; k++) begin
                np[k] = 0;
                agree = pressed[k] ? (s2[k] == 0) : (s2[k] == 1);
                if (agree) begin
                    run[k] = 0;
                end else begin
                    run[k]++;
                    if (run[k] == N + 1) begin
                        pressed[k] = !pressed[k];
                        run[k] = 0;
                        np[k] = pressed[k];
                    end
                end
                s2[k] = s1[k];
                s1[k] = raw[k];
                m_pulse[k] = np[k];
            end
        end
    endtask

    task automatic step(input bit rn, input bit ku, input bit kd, input bit cl);
        exp_t e;
        rst_n = rn; key_up_n = ku; key_dn_n = kd; clr = cl;
        model_edge(rn, ku, kd, cl);
        e.up = m_pulse[0];
        e.dn = m_pulse[1];
        e.c1 = m_c1[3:0];
        e.w1 = m_w1;
        e.c0 = m_c0[3:0];
        e.w0 = m_w0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit up, input bit dn);
        for (int i = 0; i < 10; i++) step(1, !up, !dn, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("up_pulse_wrap", up_w1, e.up);
            chk("up_pulse_sat", up_w0, e.up);
            chk("dn_pulse_wrap", dn_w1, e.dn);
            chk("dn_pulse_sat", dn_w0, e.dn);
            chk("count_wrap", count_w1, e.c1);
            chk("wrap_evt_wrap", wrap_w1, e.w1);
            chk("count_sat", count_w0, e.c0);
            chk("wrap_evt_sat", wrap_w0, e.w0);
        end
    end

    initial begin
        bit lvl[2];
        int rem[2];
        rst_n = 0; key_up_n = 1; key_dn_n = 1; clr = 0;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        chk("reset_count", count_w1, 4'd0);
        chk("reset_wrap_evt", wrap_w1, 1'b0);

        // Held up key: pulse only in cycle E0+6, count 1 from E0+7
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 1, 0);
            chk(i == 6 ? "hold_pulse" : "hold_quiet", up_w1, (i == 6) ? 1 : 0);
            if (i == 7) chk("hold_count", count_w1, 4'd1);
        end
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);

        // Bounce low3/high1 then stable low
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
            step(1, 1, 1, 0);
        end
        for (int i = 0; i < 12; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);
        chk("bounce_count", count_w1, 4'd2);

        // clr in the up_pulse cycle discards the press
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1, i == 7);
            if (i == 6) chk("clr_pulse_seen", up_w1, 1'b1);
            if (i == 7) chk("clr_count", count_w1, 4'd0);
        end
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);

        press(1, 0);
        press(1, 1);
        chk("both_keys_count", count_w1, 4'd1);

        // Wrap vs saturate at the top and bottom
        step(1, 1, 1, 1);
        for (int p = 0; p < 16; p++) press(1, 0);
        chk("wrap_top_count", count_w1, 4'd0);
        chk("sat_top_count", count_w0, 4'd15);
        press(0, 1);
        chk("wrap_bottom_count", count_w1, 4'd15);
        chk("sat_dec_count", count_w0, 4'd14);

        // Reset during PRESS_WAIT with key still held
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("midreset_count", count_w1, 4'd0);
        chk("midreset_pulse", up_w1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            chk(i == 6 ? "midreset_late_pulse" : "midreset_quiet", up_w1, (i == 6) ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);

        // Randomized bouncing keys with occasional clr and reset
        lvl[0] = 1; lvl[1] = 1; rem[0] = 0; rem[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = $urandom_range(0, 1);
                    rem[k] = $urandom_range(1, 14);
                end
                rem[k]--;
            end
            step($urandom_range(0, 799) != 0, lvl[0], lvl[1], $urandom_range(0, 39) == 0);
        end

        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/key_counter.md
KEY_COUNTER -- requirements
Module: key_counter

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable synchronized samples that qualify a key press or release (legal range 2..2^20).
REQ-002 The module SHALL have parameter WRAP, default 1, where 1 selects modulo-16 wrap and 0 selects saturation at 0/15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_up_n  input  1  raw active-low increment push-button, asynchronous to clk, bouncing.
REQ-006 key_dn_n  input  1  raw active-low decrement push-button, asynchronous to clk, bouncing.
REQ-007 clr  input  1  synchronous active-high count clear.
REQ-008 count  output  4  registered count value, feeds the downstream seven-segment decoder.
REQ-009 up_pulse  output  1  registered one-cycle strobe, qualified up press.
REQ-010 dn_pulse  output  1  registered one-cycle strobe, qualified down press.
REQ-011 wrap_evt  output  1  registered one-cycle strobe, count wrapped (15->0 or 0->15).

Function
REQ-012 Each key SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each key SHALL have an independent debounce FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a cycle counter wide enough for DEBOUNCE_CYCLES.
REQ-014 IDLE -> PRESS_WAIT when the synchronized key is 0; counter cleared.
REQ-015 PRESS_WAIT: synchronized key 1 -> IDLE, counter cleared; key 0 for DEBOUNCE_CYCLES consecutive samples -> PRESSED.
REQ-016 PRESSED -> RELEASE_WAIT when the synchronized key is 1; counter cleared.
REQ-017 RELEASE_WAIT: synchronized key 0 -> PRESSED without a new pulse; key 1 for DEBOUNCE_CYCLES consecutive samples -> IDLE.
REQ-018 The pulse SHALL be high for exactly the one cycle following the PRESS_WAIT->PRESSED transition, and never otherwise; holding a key SHALL produce one pulse (no auto-repeat).
REQ-019 Latency: with a key held low from clock edge E0 onward, the pulse SHALL be high in the cycle beginning at edge E0+2+DEBOUNCE_CYCLES.
REQ-020 Count update SHALL occur at the clock edge ending a pulse cycle, so the new count is visible one cycle after the pulse.
REQ-021 Update priority: clr=1 -> count=0; else up_pulse and dn_pulse both 1 -> no change; else up_pulse -> increment; else dn_pulse -> decrement; else hold.
REQ-022 WRAP=1: 15+1 SHALL give 0 and 0-1 SHALL give 15, with wrap_evt high in the cycle the wrapped value first appears on count.
REQ-023 WRAP=0: increment at 15 and decrement at 0 SHALL leave count unchanged; wrap_evt SHALL never assert.
REQ-024 clr SHALL NOT affect debounce FSMs; a pulse coincident with clr SHALL still appear on up_pulse/dn_pulse but SHALL be discarded for counting.
REQ-025 Releases and sub-DEBOUNCE_CYCLES glitches SHALL never change count.

Reset
REQ-026 While rst_n=0 at a clock edge: count=0, up_pulse=0, dn_pulse=0, wrap_evt=0, both FSMs=IDLE, debounce counters=0, synchronizer flops=1 (released).
REQ-027 Reset asserted mid-debounce or mid-press SHALL abort it; a key still held after reset SHALL require a full new DEBOUNCE_CYCLES qualification and then produce one pulse.
REQ-028 Without a clock edge, rst_n SHALL have no effect.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, then key_up_n held low from edge E0 -> up_pulse high only in cycle E0+6; count=1 from cycle E0+7; no further pulses while held.
REQ-030 key_up_n bounces low 3 cycles / high 1 cycle repeatedly, then stable low -> exactly one up_pulse, measured from the start of the stable low; count +1.
REQ-031 WRAP=1: count=15, one up press -> count=0 with wrap_evt one cycle; one down press -> count=15 with wrap_evt. WRAP=0: count=15, up press -> count stays 15, wrap_evt stays 0.
REQ-032 Both keys qualified in the same cycle -> both pulses high, count unchanged; clr high in an up_pulse cycle -> count=0.
REQ-033 rst_n low for one edge during PRESS_WAIT with key held -> all outputs 0; pulse arrives DEBOUNCE_CYCLES+2 cycles after reset release, not earlier.
